// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for the 5-stage pipeline with an attached multi-cycle
//   (mul/div) unit. It provides:
//     - E-stage operand forwarding (M before W, x0 never forwards)
//     - load-use stall
//     - branch flush
//     - a per-register pending scoreboard for long-latency ops, which leave
//       E into the mul/div unit and write back through W
//     - a limit on the number of long ops in flight
//
//   Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
//   cycle counters. Without it the counter outputs are tied to 0.
//
// Parameters
//   REG_ADDR_W       register address width, NUM_REGS = 2**REG_ADDR_W
//   MAX_OUTSTANDING  max in-flight long ops (1..NUM_REGS-1)
//   CNT_W            perf counter width
//
// Ports
//   clk, reset_n                  clock (rising edge), async active-low reset
//   rs1_d, rs2_d, rd_d, long_op_d D-stage regs, D instr is a long op
//   rs1_e, rs2_e, rd_e            E-stage regs
//   result_src_e_0                E instr is a load
//   pc_src_e                      taken branch/jump in E
//   issue_long_e                  long op leaves E this cycle
//   rd_m, regwrite_m              M-stage dest / write enable
//   rd_w, regwrite_w              W-stage dest / write enable
//   long_done_w, long_rd_w        long-op result written in W this cycle
//   stall_f, stall_d              hold F/D registers
//   flush_d, flush_e              bubble D/E registers
//   forward_operand_a/b_e         10 = M, 01 = W, 00 = regfile
//   sb_busy                       any scoreboard bit set (registered view)
//   stall_cycles, flush_cycles    perf counters
// ---------------------------------------------------------------------------

// Forwarding mux select for one E-stage source operand.
module hazard_fwd_sel #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  regwrite_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  regwrite_w,
    output logic [1:0]            fwd
);
    always_comb begin
        fwd = 2'b00;
        // x0 is hardwired; a write "to" it must never be forwarded.
        if (rs_e != '0) begin
            if (regwrite_m && (rd_m == rs_e))
                fwd = 2'b10;
            else if (regwrite_w && (rd_w == rs_e))
                fwd = 2'b01;
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // D stage
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  long_op_d,
    // E stage
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  result_src_e_0,
    input  logic                  pc_src_e,
    input  logic                  issue_long_e,
    // M stage
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  regwrite_m,
    // W stage
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  regwrite_w,
    input  logic                  long_done_w,
    input  logic [REG_ADDR_W-1:0] long_rd_w,
    // controls
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            forward_operand_a_e,
    output logic [1:0]            forward_operand_b_e,
    output logic                  sb_busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles
);
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int OCNT_W   = (MAX_OUTSTANDING < 2) ? 1 : $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OCNT_W-1:0] MAX_CNT = OCNT_W'(MAX_OUTSTANDING);

    // ---------------- forwarding: one selector per source operand ----------
    logic [1:0][REG_ADDR_W-1:0] rs_e;
    logic [1:0][1:0]            fwd;

    assign rs_e = {rs2_e, rs1_e};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
            .rs_e       (rs_e[g]),
            .rd_m       (rd_m),
            .regwrite_m (regwrite_m),
            .rd_w       (rd_w),
            .regwrite_w (regwrite_w),
            .fwd        (fwd[g])
        );
    end

    assign forward_operand_a_e = fwd[0];
    assign forward_operand_b_e = fwd[1];

    // ---------------- load-use ---------------------------------------------
    logic lw_stall;
    assign lw_stall = result_src_e_0 && (rd_e != '0) &&
                      ((rs1_d == rd_e) || (rs2_d == rd_e));

    // ---------------- scoreboard -------------------------------------------
    logic [NUM_REGS-1:0] pend_q, pend_eff, pend_d;
    logic [NUM_REGS-1:0] done_mask, set_mask;

    // The regfile is write-first, so a result landing in W this cycle is
    // already readable in D: drop its pending bit before the stall lookup.
    assign done_mask = long_done_w ? (NUM_REGS'(1) << long_rd_w) : '0;
    assign set_mask  = (issue_long_e && (rd_e != '0)) ? (NUM_REGS'(1) << rd_e) : '0;
    assign pend_eff  = pend_q & ~done_mask;
    // Set after clear: a new issue to the same reg keeps it pending.
    assign pend_d    = pend_eff | set_mask;

    // Index 0 is never pending (set_mask excludes it), the explicit masks
    // keep x0 out of the lookup regardless.
    logic sb_stall;
    assign sb_stall = ((rs1_d != '0) && pend_eff[rs1_d]) ||
                      ((rs2_d != '0) && pend_eff[rs2_d]) ||
                      ((rd_d  != '0) && pend_eff[rd_d]);

    // ---------------- outstanding count ------------------------------------
    logic [OCNT_W-1:0] cnt_q, cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q;
        if (issue_long_e && !long_done_w) begin
            // Issuing at the limit is prevented by cap_stall; hold rather
            // than wrap should it ever happen.
            if (cnt_q != MAX_CNT)
                cnt_nxt = cnt_q + 1'b1;
        end else if (!issue_long_e && long_done_w) begin
            // A done with nothing outstanding (e.g. a result arriving after
            // reset) is ignored instead of wrapping.
            if (cnt_q != '0)
                cnt_nxt = cnt_q - 1'b1;
        end
    end

    logic cap_stall;
    assign cap_stall = long_op_d && (cnt_nxt == MAX_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_nxt;
        end
    end

    assign sb_busy = |pend_q;

    // ---------------- stall / flush ----------------------------------------
    logic hz;
    assign hz = lw_stall || sb_stall || cap_stall;

    // A taken branch kills the D instr anyway, so it overrides the stall.
    assign stall_f = hz && !pc_src_e;
    assign stall_d = hz && !pc_src_e;
    assign flush_d = pc_src_e;
    assign flush_e = hz || pc_src_e;

    // ---------------- perf counters ----------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_e && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed self-checking bench for hazard_scoreboard (REG_ADDR_W=5,
//   MAX_OUTSTANDING=2, CNT_W=4). Inputs change 1 time unit after the rising
//   edge; outputs are sampled 1 unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    localparam int RAW = 5;
    localparam int MAX = 2;
    localparam int CW  = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic [RAW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd_w;
    logic long_op_d, result_src_e_0, pc_src_e, issue_long_e;
    logic regwrite_m, regwrite_w, long_done_w;
    logic stall_f, stall_d, flush_d, flush_e, sb_busy;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles, flush_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // {stall_f, stall_d, flush_d, flush_e}
    logic [3:0] ctl;
    assign ctl = {stall_f, stall_d, flush_d, flush_e};

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(RAW), .MAX_OUTSTANDING(MAX), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .long_op_d(long_op_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .result_src_e_0(result_src_e_0), .pc_src_e(pc_src_e), .issue_long_e(issue_long_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .long_done_w(long_done_w), .long_rd_w(long_rd_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .forward_operand_a_e(fwd_a), .forward_operand_b_e(fwd_b),
        .sb_busy(sb_busy), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    // Bench-side in-flight count, used only to flag an issue at the limit.
    int m_cnt;
    bit cap_violation;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt <= 0;
        end else begin
            if (issue_long_e && !long_done_w && m_cnt == MAX) cap_violation <= 1'b1;
            if (issue_long_e && !long_done_w) m_cnt <= m_cnt + 1;
            else if (!issue_long_e && long_done_w && m_cnt != 0) m_cnt <= m_cnt - 1;
        end
    end

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rd_d = 0; long_op_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0;
        result_src_e_0 = 0; pc_src_e = 0; issue_long_e = 0;
        rd_m = 0; regwrite_m = 0; rd_w = 0; regwrite_w = 0;
        long_done_w = 0; long_rd_w = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; idle(); #2;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL reset_ctl got=%b exp=0000", ctl); end
        n_cmp++; if ({fwd_a, fwd_b, sb_busy} !== 5'b0) begin n_bad++; $display("FAIL reset_fwd_busy got=%b exp=00000", {fwd_a, fwd_b, sb_busy}); end
        n_cmp++; if ({stall_cycles, flush_cycles} !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_cycles); end
        cyc(); reset_n = 1'b1; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b0) begin n_bad++; $display("FAIL reset_release got=%b exp=00000", {ctl, sb_busy}); end
    endtask

    task automatic test_forward();
        idle();
        rd_m = 3; regwrite_m = 1; rd_w = 3; regwrite_w = 1; rs1_e = 3; #1;
        n_cmp++; if ({fwd_a, fwd_b} !== 4'b1000) begin n_bad++; $display("FAIL fwd_m_prio got=%b exp=1000", {fwd_a, fwd_b}); end
        regwrite_m = 0; #1;
        n_cmp++; if ({fwd_a, fwd_b} !== 4'b0100) begin n_bad++; $display("FAIL fwd_w got=%b exp=0100", {fwd_a, fwd_b}); end
        rs1_e = 0; #1;
        n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL fwd_x0 got=%b exp=0000", {fwd_a, fwd_b}); end
        regwrite_m = 1; rs2_e = 3; #1;
        n_cmp++; if ({fwd_a, fwd_b} !== 4'b0010) begin n_bad++; $display("FAIL fwd_b_m got=%b exp=0010", {fwd_a, fwd_b}); end
        rd_m = 4; rs1_e = 4; #1;
        n_cmp++; if ({fwd_a, fwd_b} !== 4'b1001) begin n_bad++; $display("FAIL fwd_ab_mix got=%b exp=1001", {fwd_a, fwd_b}); end
        regwrite_w = 0; #1;
        n_cmp++; if ({fwd_a, fwd_b} !== 4'b1000) begin n_bad++; $display("FAIL fwd_w_off got=%b exp=1000", {fwd_a, fwd_b}); end
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL fwd_no_ctl got=%b exp=0000", ctl); end
        idle(); cyc();
    endtask

    task automatic test_load_use();
        idle(); result_src_e_0 = 1; rd_e = 5; rs2_d = 5; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL lw_rs2 got=%b exp=1101", ctl); end
        cyc(); idle(); #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL lw_one_cycle got=%b exp=0000", ctl); end
        result_src_e_0 = 1; rd_e = 5; rs1_d = 5; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL lw_rs1 got=%b exp=1101", ctl); end
        rd_e = 0; rs1_d = 0; rs2_d = 0; #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL lw_rd0 got=%b exp=0000", ctl); end
        rd_e = 5; rs1_d = 6; rs2_d = 4; #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL lw_nomatch got=%b exp=0000", ctl); end
        idle(); cyc();
    endtask

    task automatic test_scoreboard();
        idle(); issue_long_e = 1; rd_e = 7; #1;
        n_cmp++; if (sb_busy !== 1'b0) begin n_bad++; $display("FAIL sb_busy_before got=%b exp=0", sb_busy); end
        cyc(); idle(); rs1_d = 7; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b11011) begin n_bad++; $display("FAIL sb_raw got=%b exp=11011", {ctl, sb_busy}); end
        cyc(); #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL sb_raw_held got=%b exp=1101", ctl); end
        long_done_w = 1; long_rd_w = 7; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b00001) begin n_bad++; $display("FAIL sb_done_bypass got=%b exp=00001", {ctl, sb_busy}); end
        cyc(); idle(); rs1_d = 7; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b00000) begin n_bad++; $display("FAIL sb_cleared got=%b exp=00000", {ctl, sb_busy}); end
        // WAW on rd_d, then RAW on rs2_d
        idle(); issue_long_e = 1; rd_e = 9; cyc();
        idle(); rd_d = 9; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL sb_waw got=%b exp=1101", ctl); end
        rd_d = 0; rs2_d = 9; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL sb_rs2 got=%b exp=1101", ctl); end
        long_done_w = 1; long_rd_w = 9; #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL sb_rs2_done got=%b exp=0000", ctl); end
        cyc(); idle();
        // issue to x0 never becomes pending
        issue_long_e = 1; rd_e = 0; cyc();
        idle(); long_done_w = 1; long_rd_w = 0; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b00000) begin n_bad++; $display("FAIL sb_x0 got=%b exp=00000", {ctl, sb_busy}); end
        cyc(); idle();
        // clear and set on the same index in one cycle: set wins
        issue_long_e = 1; rd_e = 7; cyc();
        idle(); issue_long_e = 1; rd_e = 7; long_done_w = 1; long_rd_w = 7; cyc();
        idle(); rs1_d = 7; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b11011) begin n_bad++; $display("FAIL sb_set_wins got=%b exp=11011", {ctl, sb_busy}); end
        long_done_w = 1; long_rd_w = 7; cyc();
        idle(); #1;
        n_cmp++; if (sb_busy !== 1'b0) begin n_bad++; $display("FAIL sb_drained got=%b exp=0", sb_busy); end
    endtask

    task automatic test_cap();
        idle(); long_op_d = 1; rd_d = 3; rs1_d = 1; rs2_d = 2;
        issue_long_e = 1; rd_e = 4; #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL cap_one got=%b exp=0000", ctl); end
        cyc(); rd_e = 6; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL cap_nxt_max got=%b exp=1101", ctl); end
        cyc(); issue_long_e = 0; rd_e = 0; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL cap_held got=%b exp=1101", ctl); end
        long_op_d = 0; #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL cap_not_long got=%b exp=0000", ctl); end
        // issue + done together keeps the count at the limit
        long_op_d = 1; long_done_w = 1; long_rd_w = 4; issue_long_e = 1; rd_e = 8; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL cap_swap got=%b exp=1101", ctl); end
        cyc(); idle(); rs1_d = 4; #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL cap_rd4_free got=%b exp=0000", ctl); end
        rs1_d = 8; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL cap_rd8_pend got=%b exp=1101", ctl); end
        rs1_d = 0; long_op_d = 1; rd_d = 3; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL cap_cnt_kept got=%b exp=1101", ctl); end
        long_done_w = 1; long_rd_w = 6; #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL cap_done_frees got=%b exp=0000", ctl); end
        cyc(); idle(); long_done_w = 1; long_rd_w = 8; cyc();
        // done with nothing outstanding must not wrap the count
        idle(); long_done_w = 1; long_rd_w = 5; cyc();
        idle(); issue_long_e = 1; rd_e = 10; cyc();
        idle(); issue_long_e = 1; rd_e = 11; long_op_d = 1; rd_d = 3; #1;
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL cap_no_wrap got=%b exp=1101", ctl); end
        cyc(); idle(); long_done_w = 1; long_rd_w = 10; cyc();
        idle(); long_done_w = 1; long_rd_w = 11; cyc();
        idle(); #1;
        n_cmp++; if (sb_busy !== 1'b0) begin n_bad++; $display("FAIL cap_drained got=%b exp=0", sb_busy); end
    endtask

    task automatic test_branch_reset();
        idle(); issue_long_e = 1; rd_e = 7; cyc();
        idle(); rs1_d = 7; pc_src_e = 1; #1;
        n_cmp++; if (ctl !== 4'b0011) begin n_bad++; $display("FAIL br_over_sb got=%b exp=0011", ctl); end
        rs1_d = 0; #1;
        n_cmp++; if (ctl !== 4'b0011) begin n_bad++; $display("FAIL br_only got=%b exp=0011", ctl); end
        pc_src_e = 0; rs1_d = 7; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b11011) begin n_bad++; $display("FAIL br_sb_back got=%b exp=11011", {ctl, sb_busy}); end
        reset_n = 1'b0; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b00000) begin n_bad++; $display("FAIL rst_midop got=%b exp=00000", {ctl, sb_busy}); end
        n_cmp++; if ({stall_cycles, flush_cycles} !== '0) begin n_bad++; $display("FAIL rst_midop_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_cycles); end
        cyc(); reset_n = 1'b1;
        // late result from the op killed by reset
        idle(); long_done_w = 1; long_rd_w = 7; rs1_d = 7; #1;
        n_cmp++; if ({ctl, sb_busy} !== 5'b00000) begin n_bad++; $display("FAIL rst_late_done got=%b exp=00000", {ctl, sb_busy}); end
        cyc(); idle(); issue_long_e = 1; rd_e = 12; long_op_d = 1; rd_d = 3; #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL rst_cnt_zero got=%b exp=0000", ctl); end
        cyc(); idle(); long_done_w = 1; long_rd_w = 12; cyc();
        idle();
    endtask

    task automatic test_perf();
        reset_n = 1'b0; #1; reset_n = 1'b1; idle(); #1;
        n_cmp++; if ({stall_cycles, flush_cycles} !== '0) begin n_bad++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", stall_cycles, flush_cycles); end
        pc_src_e = 1;
        repeat (3) cyc();
        n_cmp++; if (flush_cycles !== (PERF ? 4'd3 : 4'd0) || stall_cycles !== 4'd0) begin
            n_bad++; $display("FAIL perf_flush_only got=%0d/%0d exp=0/%0d", stall_cycles, flush_cycles, PERF ? 3 : 0); end
        idle(); result_src_e_0 = 1; rd_e = 5; rs2_d = 5;
        repeat (5) cyc();
        n_cmp++; if (stall_cycles !== (PERF ? 4'd5 : 4'd0) || flush_cycles !== (PERF ? 4'd8 : 4'd0)) begin
            n_bad++; $display("FAIL perf_partial got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_cycles, PERF ? 5 : 0, PERF ? 8 : 0); end
        repeat (15) cyc();
        n_cmp++; if (stall_cycles !== (PERF ? 4'd15 : 4'd0) || flush_cycles !== (PERF ? 4'd15 : 4'd0)) begin
            n_bad++; $display("FAIL perf_saturate got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_cycles, PERF ? 15 : 0, PERF ? 15 : 0); end
        idle(); cyc();
    endtask

    initial begin
        cap_violation = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_scoreboard();
        test_cap();
        test_branch_reset();
        test_perf();
        n_cmp++; if (cap_violation !== 1'b0) begin n_bad++; $display("FAIL issue_at_max got=%b exp=0", cap_violation); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
